// File: rtl/accum_div_ctrl_pkg.sv
// Shared definitions for the repeated-subtraction divide sequencer.
package accum_div_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 8;

    // Encoding is fixed so the accumulator stage and integration bench can decode it.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StLoad  = 3'd2,
        StSub   = 3'd3,
        StDone  = 3'd4
    } state_t;

endpackage

// File: rtl/accum_div_ctrl_if.sv
// Request/result and accumulator-control bundle of the divide sequencer.
interface accum_div_ctrl_if
    import accum_div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] alu_b;
    logic             alu_s;
    logic             alu_e;
    logic             acc_clr;
    logic             busy;
    logic             done;
    logic             div_err;
    logic [CNT_W-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    // Requester side: issues divisions, owns the accumulator feedback.
    modport master (
        output start, dividend, divisor, acc_q,
        input  alu_b, alu_s, alu_e, acc_clr, busy, done, div_err, quotient, remainder
    );

    // Sequencer side.
    modport slave (
        input  start, dividend, divisor, acc_q,
        output alu_b, alu_s, alu_e, acc_clr, busy, done, div_err, quotient, remainder
    );

endinterface

// File: rtl/accum_div_ctrl.sv
// Unsigned divide by repeated subtraction, steering an external accumulator stage.
// CNT_W must be >= WIDTH so the quotient counter cannot wrap.
module accum_div_ctrl
    import accum_div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input logic            CLK,
    input logic            CLR,
    accum_div_ctrl_if.slave bus
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] dividend_r;
    logic [WIDTH-1:0] divisor_r;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;

    logic [WIDTH-1:0] alu_b;
    logic             alu_s;
    logic             alu_e;
    logic             acc_clr;
    logic             ge;

    // Guard keeps the subtraction from ever underflowing.
    assign ge = (bus.acc_q >= divisor_r);

    // State register.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) state <= StIdle;
        else     state <= state_next;
    end

    // Next-state and accumulator control decode.
    always_comb begin
        state_next = state;
        alu_b      = '0;
        alu_s      = 1'b0;
        alu_e      = 1'b0;
        acc_clr    = 1'b0;
        case (state)
            StIdle: begin
                if (bus.start && (bus.divisor != '0)) state_next = StClear;
            end
            StClear: begin
                acc_clr    = 1'b1;
                state_next = StLoad;
            end
            StLoad: begin
                alu_e      = 1'b1;
                alu_b      = dividend_r;
                state_next = StSub;
            end
            StSub: begin
                if (ge) begin
                    alu_e = 1'b1;
                    alu_s = 1'b1;
                    alu_b = divisor_r;
                end else begin
                    state_next = StDone;
                end
            end
            StDone:  state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    // Operand capture, quotient counting and result/status registers.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            dividend_r  <= '0;
            divisor_r   <= '0;
            count       <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            dividend_r <= bus.dividend;
                            divisor_r  <= bus.divisor;
                            count      <= '0;
                            done_r     <= 1'b0;
                            err_r      <= 1'b0;
                            busy_r     <= 1'b1;
                        end else begin
                            // Divide-by-zero resolves in place; accumulator untouched.
                            err_r       <= 1'b1;
                            done_r      <= 1'b1;
                            quotient_r  <= '0;
                            remainder_r <= bus.dividend;
                        end
                    end
                end
                StSub: begin
                    if (ge) begin
                        count <= count + CNT_W'(1);
                    end else begin
                        quotient_r  <= count;
                        remainder_r <= bus.acc_q;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_b     = alu_b;
    assign bus.alu_s     = alu_s;
    assign bus.alu_e     = alu_e;
    assign bus.acc_clr   = acc_clr;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.div_err   = err_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;

endmodule

// File: tb/tb_accum_div_ctrl.sv
// Directed bench for accum_div_ctrl with a behavioural accumulator stage.
module tb_accum_div_ctrl;

    logic clk;
    logic clr;
    int   vectors;
    int   miscompares;
    logic [7:0] acc;

    accum_div_ctrl_if #(.WIDTH(8), .CNT_W(8)) bus ();

    accum_div_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulator stage: async clear, add/subtract when enabled.
    always_ff @(posedge clk or posedge bus.acc_clr) begin
        if (bus.acc_clr)    acc <= 8'd0;
        else if (bus.alu_e) acc <= bus.alu_s ? acc - bus.alu_b : acc + bus.alu_b;
    end
    assign bus.acc_q = acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one non-zero-divisor division; start accepted at "edge 0".
    task automatic run_div(input string tag, input logic [7:0] dvd, input logic [7:0] dvs,
                           input int exp_q, input int exp_r, input bit poke);
        int edges;
        int min_acc;
        bit saw_sub;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = dvd; bus.divisor = dvs;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.dividend = 8'hA5; bus.divisor = 8'h03;
        check({tag, "_busy_edge0"}, bus.busy, 1);
        check({tag, "_done_cleared"}, bus.done, 0);
        edges = 0; min_acc = 256; saw_sub = 1'b0;
        while (!bus.done && edges < 300) begin
            bus.start = (poke && edges == 10);
            @(posedge clk);
            edges++;
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.alu_s) saw_sub = 1'b1;
            if (edges >= 2 && int'(bus.acc_q) < min_acc) min_acc = int'(bus.acc_q);
        end
        check({tag, "_latency"}, edges, exp_q + 3);
        check({tag, "_quotient"}, bus.quotient, exp_q);
        check({tag, "_remainder"}, bus.remainder, exp_r);
        check({tag, "_busy_low"}, bus.busy, 0);
        check({tag, "_div_err"}, bus.div_err, 0);
        if (exp_q == 0) check({tag, "_no_sub"}, saw_sub, 0);
        else            check({tag, "_min_acc"}, min_acc, exp_r);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_held"}, bus.done, 1);
        check({tag, "_quotient_held"}, bus.quotient, exp_q);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        clr = 1'b1;
        bus.start = 1'b0; bus.dividend = 8'd0; bus.divisor = 8'd0;
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_div_err", bus.div_err, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_ctrl", {bus.alu_e, bus.acc_clr, bus.alu_s, bus.alu_b}, 0);
        @(negedge clk);
        clr = 1'b0;

        run_div("d60_12", 8'd60, 8'd12, 5, 0, 1'b0);
        run_div("d100_7", 8'd100, 8'd7, 14, 2, 1'b0);
        run_div("d5_9", 8'd5, 8'd9, 0, 5, 1'b0);
        run_div("d0_3", 8'd0, 8'd3, 0, 0, 1'b0);

        // Divide by zero: resolved after one edge, accumulator left alone.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd42; bus.divisor = 8'd0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("dz_div_err", bus.div_err, 1);
        check("dz_done", bus.done, 1);
        check("dz_quotient", bus.quotient, 0);
        check("dz_remainder", bus.remainder, 42);
        check("dz_busy", bus.busy, 0);
        check("dz_ctrl", {bus.alu_e, bus.acc_clr}, 0);
        check("dz_acc", bus.acc_q, 0);

        run_div("d255_1", 8'd255, 8'd1, 255, 0, 1'b1);

        // Abort mid-SUB with asynchronous reset.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd60; bus.divisor = 8'd12;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_pre_busy", bus.busy, 1);
        clr = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_results", {bus.quotient, bus.remainder}, 0);
        check("abort_ctrl", {bus.alu_e, bus.acc_clr, bus.alu_s, bus.alu_b}, 0);
        @(negedge clk);
        clr = 1'b0;

        run_div("d60_12_again", 8'd60, 8'd12, 5, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
